// File: rtl/lsu_data_port.sv
`default_nettype none
// ============================================================================
// lsu_data_port : RV32I load/store unit driving a req/gnt/rvalid data port.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned H/W ops.  Rev 1.0
// ============================================================================
module lsu_data_port #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic                  lsu_we_i,
  input  logic [2:0]            lsu_funct3_i,
  input  logic [31:0]           lsu_addr_i,
  input  logic [31:0]           lsu_wdata_i,
  output logic [31:0]           lsu_rdata_o,
  output logic                  lsu_done_o,
  output logic                  lsu_misaligned_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic [31:0]           data_rdata_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t                state, state_nxt;
  logic [1:0]            size, size_nxt;
  logic [1:0]            off, off_nxt;
  logic                  sign_ext, sign_ext_nxt;
  logic                  req_nxt, we_nxt, done_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [3:0]            be_nxt;
  logic [31:0]           wdata_nxt, rdata_nxt;

  logic [1:0]            in_size;
  logic [3:0]            in_be;
  logic [31:0]           in_wdata;
  logic                  in_mis;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           load_ext;

  // Address bits above the port width are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^lsu_addr_i[31:ADDR_WIDTH];

  assign lsu_ready_o = (state == IDLE);

  // Decode of the op presented by the core; unlisted funct3 encodings act as W.
  always_comb begin
    case (lsu_funct3_i[1:0])
      2'b00:   in_size = SZ_B;
      2'b01:   in_size = SZ_H;
      default: in_size = SZ_W;
    endcase
    case (in_size)
      SZ_B: begin
        in_be    = 4'b0001 << lsu_addr_i[1:0];
        in_wdata = {4{lsu_wdata_i[7:0]}};
      end
      SZ_H: begin
        in_be    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
        in_wdata = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        in_be    = 4'b1111;
        in_wdata = lsu_wdata_i;
      end
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    in_mis = ((in_size == SZ_H) && lsu_addr_i[0]) ||
             ((in_size == SZ_W) && (lsu_addr_i[1:0] != 2'b00));
`else
    in_mis = 1'b0;
`endif
  end

  // Lane extraction and extension of returned read data.
  always_comb begin
    case (off)
      2'd0:    rd_byte = data_rdata_i[7:0];
      2'd1:    rd_byte = data_rdata_i[15:8];
      2'd2:    rd_byte = data_rdata_i[23:16];
      default: rd_byte = data_rdata_i[31:24];
    endcase
    rd_half = off[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (size)
      SZ_B:    load_ext = {{24{sign_ext & rd_byte[7]}}, rd_byte};
      SZ_H:    load_ext = {{16{sign_ext & rd_half[15]}}, rd_half};
      default: load_ext = data_rdata_i;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    size_nxt     = size;
    off_nxt      = off;
    sign_ext_nxt = sign_ext;
    req_nxt      = data_req_o;
    we_nxt       = data_we_o;
    addr_nxt     = data_addr_o;
    be_nxt       = data_be_o;
    wdata_nxt    = data_wdata_o;
    rdata_nxt    = lsu_rdata_o;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (lsu_valid_i && !in_mis) begin
          state_nxt    = REQ;
          size_nxt     = in_size;
          off_nxt      = lsu_addr_i[1:0];
          sign_ext_nxt = ~lsu_funct3_i[2];
          req_nxt      = 1'b1;
          we_nxt       = lsu_we_i;
          addr_nxt     = {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
          be_nxt       = in_be;
          wdata_nxt    = in_wdata;
        end
      end
      REQ: begin
        if (data_gnt_i) begin
          req_nxt   = 1'b0;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (data_rvalid_i) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          if (!data_we_o) rdata_nxt = load_ext;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      size         <= SZ_B;
      off          <= 2'b00;
      sign_ext     <= 1'b0;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_addr_o  <= '0;
      data_be_o    <= 4'b0000;
      data_wdata_o <= 32'h0;
      lsu_rdata_o  <= RESET_RDATA;
      lsu_done_o   <= 1'b0;
    end else begin
      state        <= state_nxt;
      size         <= size_nxt;
      off          <= off_nxt;
      sign_ext     <= sign_ext_nxt;
      data_req_o   <= req_nxt;
      data_we_o    <= we_nxt;
      data_addr_o  <= addr_nxt;
      data_be_o    <= be_nxt;
      data_wdata_o <= wdata_nxt;
      lsu_rdata_o  <= rdata_nxt;
      lsu_done_o   <= done_nxt;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lsu_misaligned_o <= 1'b0;
    else        lsu_misaligned_o <= (state == IDLE) && lsu_valid_i && in_mis;
  end
`else
  assign lsu_misaligned_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_data_port.sv
`default_nettype none
// tb_lsu_data_port : directed bench with a cycle-level reference model of the LSU.
module tb_lsu_data_port;

  localparam int          AW  = 10;
  localparam logic [31:0] RST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_valid, lsu_ready, lsu_we, lsu_done, lsu_mis;
  logic [2:0]  lsu_f3;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        data_req, data_gnt, data_rvalid, data_we;
  logic [AW-1:0] data_addr;
  logic [3:0]  data_be;
  logic [31:0] data_wdata, data_rdata;

  int checks = 0;
  int errors = 0;

  // Expected DUT outputs for the current cycle.
  logic        exp_ready = 1'b1, exp_req = 1'b0, exp_done = 1'b0, exp_mis = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0, exp_rdata = RST;
  logic [3:0]  exp_be = 4'h0;
  // Bus fields captured on the first cycle after accept.
  logic        cap_req, cap_mis;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  lsu_data_port #(.ADDR_WIDTH(AW), .RESET_RDATA(RST)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_we_i(lsu_we),
    .lsu_funct3_i(lsu_f3), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_rdata_o(lsu_rdata), .lsu_done_o(lsu_done), .lsu_misaligned_o(lsu_mis),
    .data_req_o(data_req), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
    .data_addr_o(data_addr), .data_we_o(data_we), .data_be_o(data_be),
    .data_wdata_o(data_wdata), .data_rdata_i(data_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (spec arithmetic) ----------------
  function automatic int nbytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit is_signed_ld(input logic [2:0] f3);
    return (f3 == 3'b000 || f3 == 3'b001);
  endfunction

  function automatic int m_off(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    n = nbytes(f3);
    return (int'(addr % 4) / n) * n;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int v;
    v = ((1 << nbytes(f3)) - 1) << m_off(f3, addr);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (nbytes(f3) == 1) return {24'h0, wd[7:0]} * 32'h0101_0101;
    if (nbytes(f3) == 2) return {16'h0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] addr);
    return (addr % (32'd1 << AW)) & ~32'd3;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    int n;
    longint v, span;
    n = nbytes(f3);
    if (n == 4) return rd;
    span = longint'(1) << (8 * n);
    v = (longint'({32'h0, rd}) >> (8 * m_off(f3, addr))) % span;
    if (is_signed_ld(f3) && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic bit m_trap(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    return (addr % nbytes(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("ready", {31'h0, lsu_ready}, {31'h0, exp_ready});
    chk("req", {31'h0, data_req}, {31'h0, exp_req});
    chk("done", {31'h0, lsu_done}, {31'h0, exp_done});
    chk("misaligned", {31'h0, lsu_mis}, {31'h0, exp_mis});
    chk("rdata", lsu_rdata, exp_rdata);
    if (exp_req) begin
      chk("bus_addr", {{(32-AW){1'b0}}, data_addr}, exp_addr);
      chk("bus_be", {28'h0, data_be}, {28'h0, exp_be});
      chk("bus_we", {31'h0, data_we}, {31'h0, exp_we});
      if (exp_we) chk("bus_wdata", data_wdata, exp_wdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n, input logic noise);
    for (int i = 0; i < n; i++) begin
      data_gnt = noise; data_rvalid = noise; data_rdata = $urandom;
      @(posedge clk); #1;
      exp_done = 1'b0; exp_mis = 1'b0;
    end
    data_gnt = 1'b0; data_rvalid = 1'b0;
  endtask

  // Called at posedge+1; leaves at posedge+1 of the completion edge.
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int gnt_wait, input int rv_wait,
                       input logic [31:0] rd, input logic spurious);
    data_gnt = 1'b0; data_rvalid = 1'b0;
    lsu_valid = 1'b1; lsu_we = we; lsu_f3 = f3; lsu_addr = addr; lsu_wdata = wd;
    @(posedge clk); #1;
    lsu_valid = 1'b0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_f3 = 3'($urandom);
    cap_req = data_req; cap_mis = lsu_mis; cap_addr = {{(32-AW){1'b0}}, data_addr};
    cap_be = data_be; cap_wdata = data_wdata;
    exp_done = 1'b0;
    if (m_trap(f3, addr)) begin
      exp_mis = 1'b1;
      @(posedge clk); #1;
      exp_mis = 1'b0;
      return;
    end
    exp_req = 1'b1; exp_ready = 1'b0; exp_we = we; exp_addr = m_addr(addr);
    exp_be = m_be(f3, addr); exp_wdata = m_wdata(f3, wd);
    for (int i = 0; i < gnt_wait; i++) begin
      data_rvalid = spurious; data_rdata = $urandom;
      @(posedge clk); #1;
    end
    data_rvalid = 1'b0; data_gnt = 1'b1;
    @(posedge clk); #1;
    data_gnt = 1'b0; exp_req = 1'b0;
    for (int i = 0; i < rv_wait; i++) begin
      @(posedge clk); #1;
    end
    data_rvalid = 1'b1; data_rdata = rd;
    @(posedge clk); #1;
    data_rvalid = 1'b0; data_rdata = $urandom;
    exp_done = 1'b1; exp_ready = 1'b1;
    if (!we) exp_rdata = m_load(f3, addr, rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_f3 = 3'b0; lsu_addr = 32'h0;
    lsu_wdata = 32'h0; data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = 32'h0;
    #12;
    chk("rst_ready", {31'h0, lsu_ready}, 32'h1);
    chk("rst_req", {31'h0, data_req}, 32'h0);
    chk("rst_rdata", lsu_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2, 1'b1);

    // SW, minimal latency; done visible two edges after accept-edge + 1
    do_op(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 0, 0, 32'h0, 1'b0);
    chk("sw_addr", cap_addr, 32'h010);
    chk("sw_be", {28'h0, cap_be}, 32'hF);
    chk("sw_wdata", cap_wdata, 32'hDEADBEEF);
    chk("sw_done", {31'h0, lsu_done}, 32'h1);
    // back-to-back SB during the done cycle
    do_op(1'b1, 3'b000, 32'h013, 32'h000000A5, 0, 0, 32'h0, 1'b0);
    chk("sb_be", {28'h0, cap_be}, 32'h8);
    chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    do_op(1'b0, 3'b000, 32'h013, 32'h0, 0, 0, 32'hA500_0000, 1'b0);
    chk("lb_res", lsu_rdata, 32'hFFFFFFA5);
    do_op(1'b0, 3'b100, 32'h013, 32'h0, 0, 0, 32'hA500_0000, 1'b0);
    chk("lbu_res", lsu_rdata, 32'h000000A5);
    do_op(1'b0, 3'b001, 32'h006, 32'h0, 0, 0, 32'h8001_7FFF, 1'b0);
    chk("lh_addr", cap_addr, 32'h004);
    chk("lh_be", {28'h0, cap_be}, 32'hC);
    chk("lh_res", lsu_rdata, 32'hFFFF8001);
    do_op(1'b0, 3'b101, 32'h006, 32'h0, 0, 0, 32'h8001_7FFF, 1'b0);
    chk("lhu_res", lsu_rdata, 32'h00008001);
    idle(3, 1'b1);

    // grant stall with spurious rvalid; SH with address bits above the port width
    do_op(1'b1, 3'b001, 32'h0000_F12A, 32'h5555_1234, 4, 2, 32'h0, 1'b1);
    chk("sh_wdata", cap_wdata, 32'h12341234);
    chk("sh_addr", cap_addr, 32'h128);
    chk("st_keeps_rdata", lsu_rdata, 32'h00008001);
    do_op(1'b0, 3'b011, 32'h044, 32'h0, 1, 1, 32'h1357_9BDF, 1'b0);
    do_op(1'b0, 3'b000, 32'h0F1, 32'h0, 0, 0, 32'h0000_8000, 1'b0);
    chk("lb_off1", lsu_rdata, 32'hFFFFFF80);
    do_op(1'b0, 3'b100, 32'h0F2, 32'h0, 2, 0, 32'h00C3_0000, 1'b0);
    do_op(1'b0, 3'b001, 32'h0F0, 32'h0, 0, 3, 32'h1234_5678, 1'b0);
    chk("lh_off0", lsu_rdata, 32'h00005678);
    idle(1, 1'b0);

    // misaligned LW
    do_op(1'b0, 3'b010, 32'h002, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("trap_noreq", {31'h0, cap_req}, 32'h0);
    chk("trap_pulse", {31'h0, cap_mis}, 32'h1);
    chk("trap_rdata", lsu_rdata, 32'h00005678);
`else
    chk("forced_addr", cap_addr, 32'h000);
    chk("forced_be", {28'h0, cap_be}, 32'hF);
    chk("forced_res", lsu_rdata, 32'hCAFEF00D);
`endif
    idle(2, 1'b0);

    // async reset while waiting for the response
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_f3 = 3'b010; lsu_addr = 32'h020;
    @(posedge clk); #1;
    lsu_valid = 1'b0; exp_done = 1'b0; exp_req = 1'b1; exp_ready = 1'b0; exp_we = 1'b0;
    exp_addr = m_addr(32'h020); exp_be = m_be(3'b010, 32'h020);
    data_gnt = 1'b1;
    @(posedge clk); #1;
    data_gnt = 1'b0; exp_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'h0, data_req}, 32'h0);
    chk("arst_done", {31'h0, lsu_done}, 32'h0);
    chk("arst_ready", {31'h0, lsu_ready}, 32'h1);
    exp_ready = 1'b1; exp_rdata = RST;
    @(negedge clk); #1;
    rst_n = 1'b1; data_rvalid = 1'b1; data_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    data_rvalid = 1'b0;
    chk("arst_no_done", {31'h0, lsu_done}, 32'h0);
    idle(1, 1'b0);

    do_op(1'b0, 3'b100, 32'h003, 32'h0, 0, 0, 32'h7F00_0000, 1'b0);
    chk("recover_lbu", lsu_rdata, 32'h0000007F);
    idle(2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_data_port.md
Name: lsu_data_port

Overview:
- Load/store unit between the core's execute stage and the data-side `ram_mux` port (req/gnt/rvalid protocol).
- Accepts one RV32I load/store per handshake from the core.
- Produces a word-aligned bus request with byte enables and lane-replicated write data.
- Waits for grant and response, then returns sign- or zero-extended load data to the core.

Parameters:
- ADDR_WIDTH, 10, width of byte address driven to the ram_mux port.
- RESET_RDATA, 32'h0000_0000, reset value of lsu_rdata_o.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lsu_valid_i  in  1  core presents an operation.
- lsu_ready_o  out  1  LSU can accept; high only in IDLE.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_funct3_i  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- lsu_addr_i  in  32  byte address; bits above ADDR_WIDTH ignored.
- lsu_wdata_i  in  32  store data, right-aligned.
- lsu_rdata_o  out  32  extended load result; held until next load completes.
- lsu_done_o  out  1  one-cycle pulse on completion of load or store.
- lsu_misaligned_o  out  1  one-cycle pulse on misaligned access; tied 0 without the optional feature.
- data_req_o  out  1  bus request.
- data_gnt_i  in  1  bus grant.
- data_rvalid_i  in  1  bus response valid, for both reads and writes.
- data_addr_o  out  ADDR_WIDTH  word-aligned byte address; bits [1:0] = 00.
- data_we_o  out  1  write enable.
- data_be_o  out  4  byte enables.
- data_wdata_o  out  32  lane-replicated write data.
- data_rdata_i  in  32  bus read data, valid with data_rvalid_i.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0 except lsu_ready_o=1; lsu_rdata_o=RESET_RDATA.
- All bus and core outputs are registered. lsu_ready_o is decoded from state.
- FSM states IDLE, REQ, RESP:
  - IDLE: on lsu_valid_i & lsu_ready_o, latch op, go to REQ, drive data_req_o=1 with addr/we/be/wdata next cycle.
  - REQ: hold data_req_o and all bus fields stable until data_gnt_i is sampled high. On that edge, drop data_req_o and go to RESP.
  - RESP: wait for data_rvalid_i. On that edge, go to IDLE, pulse lsu_done_o. For a load, update lsu_rdata_o the same edge.
- Minimum latency with gnt in the first REQ cycle and rvalid one cycle later: accept edge T0, req T1, gnt T1, rvalid T2, done T3.
- Back-to-back: ready is high during the done cycle, so a new op can be accepted then.
- Byte enables (off = addr[1:0]):
  - B/BU: 1<<off.
  - H/HU: 0011 if addr[1]=0, else 1100.
  - W: 1111.
- Write data: SB replicates wdata[7:0] into all four lanes; SH replicates wdata[15:0] into both halves; SW passes through.
- Load extract: select the byte or half from data_rdata_i using the latched offset.
  - B/H sign-extend from bit 7/15.
  - BU/HU zero-extend.
  - W passes through.
- Unlisted funct3 (011, 110, 111): treated as W.
- data_gnt_i outside REQ and data_rvalid_i outside RESP are ignored.
- lsu_valid_i while not ready is ignored; the core must hold the request.
- Stores do not modify lsu_rdata_o.
- Without the feature, misaligned addresses are forced aligned: H uses addr[1] only; W ignores addr[1:0].

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - An accepted op with H/HU and addr[0]=1, or W and addr[1:0]!=00, issues no bus request.
  - lsu_misaligned_o pulses one cycle after accept; lsu_done_o stays 0.
  - lsu_rdata_o is unchanged; state returns to IDLE.
- Undefined: lsu_misaligned_o tied 0 and forced-alignment rule applies.

Test Plan:
- SW addr 0x010 data 0xDEADBEEF, gnt immediate, rvalid next cycle -> data_addr_o=0x010, be=1111, wdata=0xDEADBEEF, we=1; done at T3.
- SB addr 0x013 data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5; then LB addr 0x013 with rdata 0xA5000000 -> lsu_rdata_o=0xFFFFFFA5; LBU -> 0x000000A5.
- LH addr 0x006 with rdata 0x80017FFF -> be=1100 addr=0x004, result 0xFFFF8001; LHU -> 0x00008001.
- Grant stall: gnt held low 4 cycles -> req, addr, be, wdata stable all 4 cycles; single done after rvalid; spurious rvalid during REQ ignored.
- rst_n low while in RESP -> req=0, done=0, ready=1 immediately (async); later rvalid produces no done.
- With LSU_MISALIGN_TRAP_EN: LW addr 0x002 -> no data_req_o, lsu_misaligned_o pulse 1 cycle after accept. Without the macro: same op reads address 0x000, be=1111.
